// File: rtl/sequential_unsigned_comparator_fsm.sv
// Bit-serial unsigned magnitude comparator for two 32-bit operands.
// Operands shift out LSB-first into a three-state relation tracker; OP freezes the session and enables a one-hot result.

module seq_cmp_shift_reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        hold,
  input  logic [31:0] din,
  output logic        lsb
);

  logic [31:0] sr_q;
  logic [31:0] sr_d;

  // Next contents: parallel load, freeze, or zero-filled right shift.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (hold) begin
      sr_d = sr_q;
    end else begin
      sr_d = {1'b0, sr_q[31:1]};
    end
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= 32'd0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign lsb = sr_q[0];

endmodule

module sequential_unsigned_comparator_fsm (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  output logic [2:0]  compare,
  input  logic        OP
);

  typedef enum logic [1:0] {
    ST_EQ = 2'd0,
    ST_GT = 2'd1,
    ST_LT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   bit_a;
  logic   bit_b;
  logic   shift_hold;

  // OP only freezes the registers; a simultaneous load still takes priority inside each register.
  assign shift_hold = OP;

  seq_cmp_shift_reg32 u_sa (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .hold (shift_hold),
    .din  (x1),
    .lsb  (bit_a)
  );

  seq_cmp_shift_reg32 u_sb (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .hold (shift_hold),
    .din  (x2),
    .lsb  (bit_b)
  );

  function automatic logic [2:0] decode_relation(input state_t st);
    logic [2:0] code;
    case (st)
      ST_EQ:   code = 3'b010;
      ST_GT:   code = 3'b100;
      ST_LT:   code = 3'b001;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  // Relation tracker: a later (more significant) differing bit overrides any earlier verdict.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_EQ;
    end else if (OP) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_EQ, ST_GT, ST_LT: begin
          case ({bit_a, bit_b})
            2'b10:   state_d = ST_GT;
            2'b01:   state_d = ST_LT;
            default: state_d = state_q;
          endcase
        end
        default: state_d = ST_EQ;
      endcase
    end
  end

  // State register with synchronous reset to the start state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Result is combinational so it is valid in the same cycle OP rises.
  always_comb begin
    compare = 3'b000;
    if (OP) begin
      compare = decode_relation(state_q);
    end else begin
      compare = 3'b000;
    end
  end

endmodule

// File: tb/tb_sequential_unsigned_comparator_fsm.sv
// Directed self-checking bench for the bit-serial comparator.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.

module tb_sequential_unsigned_comparator_fsm;

  logic [31:0] x1;
  logic [31:0] x2;
  logic        clk;
  logic        rst;
  logic        load;
  logic        OP;
  logic [2:0]  compare;

  int total_cnt;
  int bad_cnt;

  sequential_unsigned_comparator_fsm dut (
    .x1      (x1),
    .x2      (x2),
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .compare (compare),
    .OP      (OP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total_cnt = total_cnt + 1;
    if (got !== exp) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [31:0] a, input logic [31:0] b);
    x1   = a;
    x2   = b;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic shift_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_val(tag, compare, 3'b000);
    end
  endtask

  task automatic finish_session(input string tag, input logic [2:0] exp);
    OP = 1'b1;
    #1;
    check_val(tag, compare, exp);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val({tag, "_hold"}, compare, exp);
    end
    OP = 1'b0;
    #1;
    check_val({tag, "_off"}, compare, 3'b000);
  endtask

  task automatic run_session(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input int nshift, input logic [2:0] exp);
    load_ops(a, b);
    shift_n(nshift, {tag, "_shift"});
    finish_session(tag, exp);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    x1   = 32'd0;
    x2   = 32'd0;
    load = 1'b0;
    OP   = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    check_val("reset_op0", compare, 3'b000);
    rst = 1'b0;
    OP  = 1'b1;
    #1;
    check_val("reset_op1", compare, 3'b010);
    OP = 1'b0;
    #1;

    run_session("eq",       32'hB42D8C3D, 32'hB42D8C3D, 32, 3'b010);
    run_session("lt",       32'h942D8C2C, 32'h9E2D8C3D, 32, 3'b001);
    run_session("gt",       32'hB42DCC3D, 32'hB42D8C3D, 32, 3'b100);
    run_session("msb_gt",   32'h80000000, 32'h7FFFFFFF, 32, 3'b100);
    run_session("one_zero", 32'h00000001, 32'h00000000, 32, 3'b100);
    run_session("zero_max", 32'h00000000, 32'hFFFFFFFF, 32, 3'b001);
    run_session("max_gt",   32'hFFFFFFFF, 32'hFFFFFFFE, 32, 3'b100);
    run_session("lsb_lt",   32'h12345678, 32'h12345679, 32, 3'b001);
    run_session("overrun",  32'h80000000, 32'h7FFFFFFF, 40, 3'b100);

    // Reset mid-session of the GT case, then a fresh all-zero session.
    load_ops(32'hB42DCC3D, 32'hB42D8C3D);
    shift_n(10, "mid_shift");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst", compare, 3'b000);
    run_session("after_rst", 32'h00000000, 32'h00000000, 32, 3'b010);

    // Reset while OP is high forces the EQ code on that edge.
    load_ops(32'h00000000, 32'h00000001);
    shift_n(32, "rstop_shift");
    OP = 1'b1;
    #1;
    check_val("rstop_pre", compare, 3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rstop_post", compare, 3'b010);
    OP = 1'b0;
    #1;

    // Load together with OP: load wins and the state returns to EQ.
    load_ops(32'h00000005, 32'h00000003);
    shift_n(32, "ldop_shift");
    OP = 1'b1;
    #1;
    check_val("ldop_pre", compare, 3'b100);
    x1   = 32'h00000003;
    x2   = 32'h00000005;
    load = 1'b1;
    tick();
    load = 1'b0;
    check_val("ldop_post", compare, 3'b010);
    OP = 1'b0;
    #1;
    shift_n(32, "ldop_reshift");
    finish_session("ldop_final", 3'b001);

    // Mid-session reload restarts with new operands.
    load_ops(32'hFFFFFFFF, 32'h00000000);
    shift_n(5, "reload_shift");
    run_session("reload", 32'h00010000, 32'h00020000, 32, 3'b001);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
